// File: rtl/event_logger_pkg.sv
// rtl/event_logger_pkg.sv - shared constants and helpers for the event logger
package event_logger_pkg;

  localparam int LOST_W = 32;

  // Increment that holds at all-ones instead of wrapping
  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    return (v == {LOST_W{1'b1}}) ? v : v + LOST_W'(1);
  endfunction

endpackage

// File: rtl/logger_fifo.sv
// rtl/logger_fifo.sv - synchronous show-ahead FIFO holding captured events
module logger_fifo #(
  parameter int ENTRY_W = 80,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         din,
  output logic [ENTRY_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_pop_ok;
  logic               w_push_ok;

  // Extra pointer bit separates full (MSBs differ) from empty (pointers equal)
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign count     = r_count;

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer and occupancy update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + CW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + CW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/event_logger.sv
// rtl/event_logger.sv - timestamps flagged monitor events into a host-readable FIFO
module event_logger
  import event_logger_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_event,
  input  logic [WIDTH-1:0]         i_dut_ia,
  input  logic [WIDTH-1:0]         i_dut_ib,
  input  logic [WIDTH-1:0]         i_dut_os,
  input  logic                     i_freeze,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_a,
  output logic [WIDTH-1:0]         o_b,
  output logic [WIDTH-1:0]         o_s,
  output logic [TS_WIDTH-1:0]      o_timestamp,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic [LOST_W-1:0]        o_lost_ctr
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 3*WIDTH + TS_WIDTH;

  logic [TS_WIDTH-1:0] r_ts;
  logic [LOST_W-1:0]   r_lost;
  logic                w_req;
  logic                w_pop_acc;
  logic                w_full;
  logic                w_empty;
  logic [AW:0]         w_count;
  logic [ENTRY_W-1:0]  w_din;
  logic [ENTRY_W-1:0]  w_dout;

  assign w_req     = i_event && !i_freeze;
  assign w_pop_acc = i_pop && !w_empty;
  assign w_din     = {i_dut_ia, i_dut_ib, i_dut_os, r_ts};

  logger_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_req),
    .pop   (i_pop),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign o_valid     = !w_empty;
  assign o_count     = w_count;
  assign o_full      = w_full;
  assign o_lost_ctr  = r_lost;
  assign o_a         = w_dout[ENTRY_W-1 -: WIDTH];
  assign o_b         = w_dout[ENTRY_W-WIDTH-1 -: WIDTH];
  assign o_s         = w_dout[TS_WIDTH +: WIDTH];
  assign o_timestamp = w_dout[TS_WIDTH-1:0];

  // Free-running cycle stamp, independent of freeze
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Count events dropped because the FIFO was full and nothing was popped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lost <= '0;
    end else if (w_req && w_full && !w_pop_acc) begin
      r_lost <= sat_inc(r_lost);
    end
  end

endmodule

// File: tb/tb_event_logger.sv
// tb/tb_event_logger.sv - scoreboard bench for event_logger
module tb_event_logger;

  localparam int WIDTH    = 16;
  localparam int DEPTH    = 16;
  localparam int TS_WIDTH = 32;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic [31:0] ts;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_event;
  logic [15:0] i_dut_ia;
  logic [15:0] i_dut_ib;
  logic [15:0] i_dut_os;
  logic        i_freeze;
  logic        i_pop;
  logic        o_valid;
  logic [15:0] o_a;
  logic [15:0] o_b;
  logic [15:0] o_s;
  logic [31:0] o_timestamp;
  logic [4:0]  o_count;
  logic        o_full;
  logic [31:0] o_lost_ctr;

  entry_t      q[$];
  logic [31:0] m_ts;
  logic [31:0] m_lost;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  event_logger #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .TS_WIDTH (TS_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_event     (i_event),
    .i_dut_ia    (i_dut_ia),
    .i_dut_ib    (i_dut_ib),
    .i_dut_os    (i_dut_os),
    .i_freeze    (i_freeze),
    .i_pop       (i_pop),
    .o_valid     (o_valid),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_s         (o_s),
    .o_timestamp (o_timestamp),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_lost_ctr  (o_lost_ctr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 64'(o_count), 64'(q.size()));
    chk({tag, ".valid"}, 64'(o_valid), 64'(q.size() != 0));
    chk({tag, ".full"}, 64'(o_full), 64'(q.size() == DEPTH));
    chk({tag, ".lost"}, 64'(o_lost_ctr), 64'(m_lost));
    if (q.size() != 0) begin
      chk({tag, ".head_a"}, 64'(o_a), 64'(q[0].a));
      chk({tag, ".head_b"}, 64'(o_b), 64'(q[0].b));
      chk({tag, ".head_s"}, 64'(o_s), 64'(q[0].s));
      chk({tag, ".head_ts"}, 64'(o_timestamp), 64'(q[0].ts));
    end
  endtask

  // One clock cycle of stimulus, entered and left just after a falling edge
  task automatic step(input logic ev, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] s, input logic frz, input logic pop);
    entry_t e;
    i_event  = ev;
    i_dut_ia = a;
    i_dut_ib = b;
    i_dut_os = s;
    i_freeze = frz;
    i_pop    = pop;
    #1;
    if (pop && q.size() != 0) begin
      e = q.pop_front();
      chk("pop.valid", 64'(o_valid), 64'd1);
      chk("pop.a", 64'(o_a), 64'(e.a));
      chk("pop.b", 64'(o_b), 64'(e.b));
      chk("pop.s", 64'(o_s), 64'(e.s));
      chk("pop.ts", 64'(o_timestamp), 64'(e.ts));
    end
    if (ev && !frz) begin
      if (q.size() < DEPTH) begin
        e.a = a; e.b = b; e.s = s; e.ts = m_ts;
        q.push_back(e);
      end else if (m_lost != 32'hFFFFFFFF) begin
        m_lost = m_lost + 32'd1;
      end
    end
    @(posedge clk);
    m_ts = m_ts + 32'd1;
    @(negedge clk);
    i_event = 1'b0;
    i_pop   = 1'b0;
    i_freeze = 1'b0;
  endtask

  task automatic do_reset(input logic ev);
    reset   = 1'b1;
    i_event = ev;
    @(posedge clk);
    q.delete();
    m_ts   = 32'd0;
    m_lost = 32'd0;
    @(negedge clk);
    reset   = 1'b0;
    i_event = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    i_event  = 1'b0;
    i_dut_ia = '0;
    i_dut_ib = '0;
    i_dut_os = '0;
    i_freeze = 1'b0;
    i_pop    = 1'b0;
    m_ts     = 32'd0;
    m_lost   = 32'd0;
    @(negedge clk);
    do_reset(1'b0);
    chk("rst.valid", 64'(o_valid), 64'd0);
    chk("rst.count", 64'(o_count), 64'd0);
    chk("rst.full", 64'(o_full), 64'd0);
    chk("rst.lost", 64'(o_lost_ctr), 64'd0);

    // Single capture after five idle cycles
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h1234, 16'h0F0F, 16'h0000, 1'b0, 1'b0);
    chk("single.ts_const", 64'(o_timestamp), 64'd5);
    chk("single.a_const", 64'(o_a), 64'h1234);
    chk_state("single");
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk_state("single_pop");

    // Fill and overflow: 20 back-to-back events
    for (int i = 0; i < 20; i++)
      step(1'b1, 16'(i + 16'h100), 16'(~i), 16'(i * 3), 1'b0, 1'b0);
    chk("fill.full_const", 64'(o_full), 64'd1);
    chk("fill.count_const", 64'(o_count), 64'd16);
    chk("fill.lost_const", 64'(o_lost_ctr), 64'd4);
    chk_state("fill");

    // Full with simultaneous push and pop
    step(1'b1, 16'hBEEF, 16'hCAFE, 16'hF00D, 1'b0, 1'b1);
    chk("fullpp.count_const", 64'(o_count), 64'd16);
    chk("fullpp.lost_const", 64'(o_lost_ctr), 64'd4);
    chk_state("fullpp");
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk_state("drain");

    // Freeze suppresses both capture and loss counting
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i), 16'h5555, 16'hAAAA, 1'b1, 1'b0);
    chk("frz.count_const", 64'(o_count), 64'd0);
    chk("frz.lost_const", 64'(o_lost_ctr), 64'd0);
    step(1'b1, 16'h0042, 16'h0043, 16'h0044, 1'b0, 1'b0);
    chk("frz.after_const", 64'(o_count), 64'd1);
    chk_state("frz_after");
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Pop while empty together with a push
    chk_state("empty_pp_pre");
    step(1'b1, 16'h7777, 16'h8888, 16'h9999, 1'b0, 1'b1);
    chk("emptypp.count_const", 64'(o_count), 64'd1);
    chk_state("empty_pp");
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Reset mid-operation with an event coincident with reset
    for (int i = 0; i < 18; i++) step(1'b1, 16'(i), 16'(i + 7), 16'(i ^ 16'h3C), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk("mid.count_const", 64'(o_count), 64'd7);
    chk("mid.lost_const", 64'(o_lost_ctr), 64'd2);
    do_reset(1'b1);
    chk("midrst.valid", 64'(o_valid), 64'd0);
    chk("midrst.count", 64'(o_count), 64'd0);
    chk("midrst.lost", 64'(o_lost_ctr), 64'd0);
    step(1'b1, 16'hABCD, 16'h1111, 16'h2222, 1'b0, 1'b0);
    chk("midrst.ts0", 64'(o_timestamp), 64'd0);
    chk_state("midrst_after");
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    chk_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
